// File: rtl/cpu_state_dumper.sv
// Streams the CPU register file and low data-memory bytes out as tagged words while freezing the CPU.
// Optional trailer checksum word is built only when DUMP_CHECKSUM_EN is defined.
module cpu_state_dumper #(
  parameter int REG_COUNT = 32,
  parameter int MEM_BYTES = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dump_req_i,
  output logic [4:0]  rf_addr_o,
  input  logic [31:0] rf_data_i,
  output logic [6:0]  dm_addr_o,
  input  logic [7:0]  dm_data_i,
  output logic        freeze_o,
  output logic        busy_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic [1:0]  out_tag_o,
  output logic        out_last_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_REG,
    S_GATHER,
    S_MEM
`ifdef DUMP_CHECKSUM_EN
    , S_TRL
`endif
  } state_t;

  localparam logic [5:0] REG_END = 6'(REG_COUNT);
  localparam logic [7:0] MEM_END = 8'(MEM_BYTES);

  state_t      state;
  logic [31:0] cyc_cnt;
  logic [31:0] data;
  logic [23:0] gather_buf;
  logic [5:0]  reg_ptr;
  logic [7:0]  mem_ptr;
  logic [1:0]  gcnt;
  logic [1:0]  tag;
  logic        valid;
  logic        last;
  logic        done;
  logic        busy;
  logic        accept;
`ifdef DUMP_CHECKSUM_EN
  logic [31:0] chk;
`endif

  assign accept      = valid & out_ready_i;
  assign rf_addr_o   = reg_ptr[4:0];
  assign dm_addr_o   = mem_ptr[6:0];
  assign freeze_o    = busy;
  assign busy_o      = busy;
  assign out_valid_o = valid;
  assign out_data_o  = data;
  assign out_tag_o   = tag;
  assign out_last_o  = last;
  assign done_o      = done;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cyc_cnt <= '0;
    else       cyc_cnt <= cyc_cnt + 32'd1;
  end

  // reg_ptr runs one ahead of the presented register, so it equals REG_COUNT while the last one is shown
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      data       <= '0;
      gather_buf <= '0;
      reg_ptr    <= '0;
      mem_ptr    <= '0;
      gcnt       <= '0;
      tag        <= '0;
      valid      <= 1'b0;
      last       <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      chk        <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          reg_ptr <= '0;
          mem_ptr <= '0;
          gcnt    <= '0;
`ifdef DUMP_CHECKSUM_EN
          chk     <= '0;
`endif
          if (dump_req_i) begin
            data  <= cyc_cnt;
            tag   <= 2'd0;
            valid <= 1'b1;
            last  <= 1'b0;
            busy  <= 1'b1;
            state <= S_HDR;
          end
        end
        S_HDR, S_REG: begin
          if (accept) begin
`ifdef DUMP_CHECKSUM_EN
            chk <= chk ^ data;
`endif
            if (state == S_REG && reg_ptr == REG_END) begin
              valid <= 1'b0;
              gcnt  <= '0;
              state <= S_GATHER;
            end else begin
              data    <= rf_data_i;
              tag     <= 2'd1;
              reg_ptr <= reg_ptr + 6'd1;
              state   <= S_REG;
            end
          end
        end
        S_GATHER: begin
          // bytes enter at the top and shift down, so byte a ends up in the low lane
          gather_buf <= {dm_data_i, gather_buf[23:8]};
          mem_ptr    <= mem_ptr + 8'd1;
          gcnt       <= gcnt + 2'd1;
          if (gcnt == 2'd3) begin
            data  <= {dm_data_i, gather_buf};
            tag   <= 2'd2;
            valid <= 1'b1;
            state <= S_MEM;
`ifndef DUMP_CHECKSUM_EN
            last  <= (mem_ptr + 8'd1 == MEM_END);
`endif
          end
        end
        S_MEM: begin
          if (accept) begin
`ifdef DUMP_CHECKSUM_EN
            chk <= chk ^ data;
`endif
            if (mem_ptr != MEM_END) begin
              valid <= 1'b0;
              state <= S_GATHER;
            end else begin
`ifdef DUMP_CHECKSUM_EN
              data  <= chk ^ data;
              tag   <= 2'd3;
              last  <= 1'b1;
              state <= S_TRL;
`else
              valid <= 1'b0;
              last  <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_IDLE;
`endif
            end
          end
        end
`ifdef DUMP_CHECKSUM_EN
        S_TRL: begin
          if (accept) begin
            valid <= 1'b0;
            last  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
